// File: rtl/countdown_pkg.sv
// Shared encodings and BCD helpers for the countdown run controller.
// Time digits are held as {hr_10, hr_1, min_10, min_1, sec_10, sec_1}.
package countdown_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StPause   = 2'd2,
    StExpired = 2'd3
  } state_e;

  localparam logic [3:0] SepNibble = 4'hF;
  localparam logic [3:0] TensMax   = 4'd5;
  localparam logic [3:0] UnitsMax  = 4'd9;

  function automatic logic [3:0] clamp_digit(logic [3:0] d, logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

  // Strip separator nibbles from a packed time and clamp each digit to its range.
  function automatic logic [23:0] clamp_time(logic [31:0] v);
    logic [23:0] r;
    r[23:20] = clamp_digit(v[31:28], UnitsMax);
    r[19:16] = clamp_digit(v[27:24], UnitsMax);
    r[15:12] = clamp_digit(v[19:16], TensMax);
    r[11:8]  = clamp_digit(v[15:12], UnitsMax);
    r[7:4]   = clamp_digit(v[7:4],   TensMax);
    r[3:0]   = clamp_digit(v[3:0],   UnitsMax);
    return r;
  endfunction

  function automatic logic [31:0] pack_time(logic [23:0] d);
    return {d[23:16], SepNibble, d[15:8], SepNibble, d[7:0]};
  endfunction

  // One-second decrement with borrow; digits 1 and 3 are the tens of sec/min.
  function automatic logic [23:0] bcd_dec(logic [23:0] d);
    logic [23:0] r;
    logic        borrow;
    r      = d;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (borrow) begin
        if (r[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = (i == 1 || i == 3) ? TensMax : UnitsMax;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_hold_pulse.sv
// Emits a single-cycle pulse once a button has been held for HOLD_CYC consecutive cycles.
module btn_hold_pulse #(
  parameter int unsigned HOLD_CYC = 2500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned    CntW     = $clog2(HOLD_CYC + 1);
  localparam logic [CntW-1:0] HoldMax  = CntW'(HOLD_CYC);
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Count saturates at HOLD_CYC so a continued hold never re-fires.
  always_comb begin
    cnt_d = cnt_q;
    if (!btn) begin
      cnt_d = '0;
    end else if (cnt_q != HoldMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign pulse = btn && (cnt_q == HoldLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_run_ctrl.sv
// Countdown timer controller: IDLE/RUN/PAUSE/EXPIRED FSM with BCD h:m:s count and
// debounced start/clear buttons.
module countdown_run_ctrl
  import countdown_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100000000,
  parameter int unsigned HOLD_CYC  = 2500000,
  parameter int unsigned ALARM_SEC = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] load_val,
  input  logic        start,
  input  logic        clear,
  output logic [31:0] display,
  output logic [1:0]  state,
  output logic        running,
  output logic        alarm
);

  localparam int unsigned     PreW     = $clog2(CLK_HZ + 1);
  localparam logic [PreW-1:0] PreLast  = PreW'(CLK_HZ - 1);
  localparam int unsigned     AsW      = $clog2(ALARM_SEC + 1);
  localparam logic [AsW-1:0]  AsLast   = AsW'(ALARM_SEC - 1);

  logic start_p, clear_p, start_go, tick;
  logic [23:0] load_clamped, cnt_dec;

  state_e          state_q, state_d;
  logic [23:0]     cnt_q, cnt_d;
  logic [PreW-1:0] presc_q, presc_d;
  logic [AsW-1:0]  asec_q, asec_d;
  logic            running_q, running_d, alarm_q, alarm_d;

  btn_hold_pulse #(.HOLD_CYC(HOLD_CYC)) u_start_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (start),
    .pulse (start_p)
  );

  btn_hold_pulse #(.HOLD_CYC(HOLD_CYC)) u_clear_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (clear),
    .pulse (clear_p)
  );

  always_comb begin
    load_clamped = clamp_time(load_val);
    cnt_dec      = bcd_dec(cnt_q);
    tick         = (presc_q == PreLast);
    start_go     = start_p && !clear_p;
    state_d      = state_q;
    cnt_d        = cnt_q;
    presc_d      = presc_q;
    asec_d       = asec_q;
    case (state_q)
      StIdle: begin
        if (start_go && (load_clamped != '0)) begin
          cnt_d   = load_clamped;
          presc_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        presc_d = tick ? '0 : presc_q + PreW'(1);
        if (tick) cnt_d = cnt_dec;
        // Reaching zero outranks any button pulse on the same edge.
        if (tick && (cnt_dec == '0)) begin
          state_d = StExpired;
          presc_d = '0;
          asec_d  = '0;
        end else if (clear_p) begin
          state_d = StIdle;
        end else if (start_go) begin
          state_d = StPause;
        end
      end
      StPause: begin
        if (clear_p) begin
          state_d = StIdle;
        end else if (start_go) begin
          state_d = StRun;
        end
      end
      default: begin
        presc_d = tick ? '0 : presc_q + PreW'(1);
        if (tick) asec_d = asec_q + AsW'(1);
        if ((tick && (asec_q == AsLast)) || start_p || clear_p) begin
          state_d = StIdle;
          presc_d = '0;
          asec_d  = '0;
        end
      end
    endcase
    running_d = (state_d == StRun);
    alarm_d   = (state_d == StExpired);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      presc_q   <= '0;
      asec_q    <= '0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      asec_q    <= asec_d;
      running_q <= running_d;
      alarm_q   <= alarm_d;
    end
  end

  assign display = (state_q == StIdle) ? pack_time(load_clamped) : pack_time(cnt_q);
  assign state   = state_q;
  assign running = running_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_run_ctrl.sv
// Bench for countdown_run_ctrl: directed scenarios plus randomized button/load traffic
// checked every cycle against a seconds-based reference model.
module tb_countdown_run_ctrl;

  localparam int unsigned CLK_HZ    = 10;
  localparam int unsigned HOLD_CYC  = 3;
  localparam int unsigned ALARM_SEC = 2;

  logic        clk = 1'b0;
  logic        rst, start, clear;
  logic [31:0] load_val, display;
  logic [1:0]  state;
  logic        running, alarm;

  always #5 clk = ~clk;

  countdown_run_ctrl #(
    .CLK_HZ    (CLK_HZ),
    .HOLD_CYC  (HOLD_CYC),
    .ALARM_SEC (ALARM_SEC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load_val (load_val),
    .start    (start),
    .clear    (clear),
    .display  (display),
    .state    (state),
    .running  (running),
    .alarm    (alarm)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: remaining time as plain seconds, state as 0..3.
  int m_state = 0, m_secs = 0, m_presc = 0, m_asec = 0, m_sc = 0, m_cc = 0;

  function automatic int clamp_dig(int d, int mx);
    return (d > mx) ? mx : d;
  endfunction

  function automatic int load_secs(logic [31:0] v);
    int h, m, s;
    h = clamp_dig(int'(v[31:28]), 9) * 10 + clamp_dig(int'(v[27:24]), 9);
    m = clamp_dig(int'(v[19:16]), 5) * 10 + clamp_dig(int'(v[15:12]), 9);
    s = clamp_dig(int'(v[7:4]), 5) * 10 + clamp_dig(int'(v[3:0]), 9);
    return h * 3600 + m * 60 + s;
  endfunction

  function automatic logic [31:0] to_disp(int secs);
    int h, m, s;
    h = secs / 3600;
    m = (secs / 60) % 60;
    s = secs % 60;
    return {4'(h / 10), 4'(h % 10), 4'hF, 4'(m / 10), 4'(m % 10), 4'hF,
            4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance model and DUT one clock with current inputs, then compare all outputs.
  task automatic step();
    bit sp, cp, tick;
    sp = start && (m_sc == HOLD_CYC - 1);
    cp = clear && (m_cc == HOLD_CYC - 1);
    m_sc = start ? ((m_sc < HOLD_CYC) ? m_sc + 1 : m_sc) : 0;
    m_cc = clear ? ((m_cc < HOLD_CYC) ? m_cc + 1 : m_cc) : 0;
    if (rst) begin
      m_state = 0; m_secs = 0; m_presc = 0; m_asec = 0; m_sc = 0; m_cc = 0;
    end else begin
      case (m_state)
        0: if (sp && !cp && load_secs(load_val) != 0) begin
          m_secs = load_secs(load_val); m_presc = 0; m_state = 1;
        end
        1: begin
          tick = (m_presc == CLK_HZ - 1);
          m_presc = tick ? 0 : m_presc + 1;
          if (tick) m_secs--;
          if (tick && m_secs == 0) begin
            m_state = 3; m_presc = 0; m_asec = 0;
          end else if (cp) m_state = 0;
          else if (sp) m_state = 2;
        end
        2: if (cp) m_state = 0; else if (sp) m_state = 1;
        default: begin
          tick = (m_presc == CLK_HZ - 1);
          m_presc = tick ? 0 : m_presc + 1;
          if (tick) m_asec++;
          if ((tick && m_asec == ALARM_SEC) || sp || cp) begin
            m_state = 0; m_presc = 0;
          end
        end
      endcase
    end
    @(posedge clk);
    #1;
    chk("state", 32'(state), 32'(m_state));
    chk("running", 32'(running), 32'(m_state == 1));
    chk("alarm", 32'(alarm), 32'(m_state == 3));
    chk("display", display, (m_state == 0) ? to_disp(load_secs(load_val)) : to_disp(m_secs));
  endtask

  task automatic hold(int n, bit st, bit cl);
    for (int i = 0; i < n; i++) begin
      start = st;
      clear = cl;
      step();
    end
    start = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    int trans;
    logic [1:0] prev;
    rst = 1'b1; start = 1'b0; clear = 1'b0; load_val = 32'h00F00F03;
    step();
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_running", 32'(running), 32'd0);
    chk("reset_alarm", 32'(alarm), 32'd0);
    rst = 1'b0;
    step();
    chk("post_reset_disp", display, 32'h00F00F03);

    // 3-second run to expiry and alarm timeout
    hold(3, 1'b1, 1'b0);
    chk("s034_run", 32'(state), 32'd1);
    repeat (30) step();
    chk("s034_zero_disp", display, 32'h00F00F00);
    chk("s034_expired", 32'(state), 32'd3);
    chk("s034_alarm", 32'(alarm), 32'd1);
    repeat (20) step();
    chk("s034_idle", 32'(state), 32'd0);

    // Hour borrow, then pause holds display
    load_val = 32'h01F00F00;
    hold(3, 1'b1, 1'b0);
    repeat (10) step();
    chk("s035_borrow", display, 32'h00F59F59);
    hold(3, 1'b1, 1'b0);
    chk("s035_pause", 32'(state), 32'd2);
    repeat (50) step();
    chk("s035_held_disp", display, 32'h00F59F59);
    chk("s035_still_pause", 32'(state), 32'd2);
    hold(3, 1'b0, 1'b1);
    chk("s035_clear", 32'(state), 32'd0);

    // Digit clamping
    load_val = 32'h12F3CF78;
    step();
    chk("s036_clamp_idle", display, 32'h12F39F58);
    hold(3, 1'b1, 1'b0);
    chk("s036_run", 32'(state), 32'd1);
    chk("s036_latched", display, 32'h12F39F58);
    hold(3, 1'b0, 1'b1);

    // Simultaneous start and clear in RUN
    load_val = 32'h00F05F00;
    hold(3, 1'b1, 1'b0);
    repeat (4) step();
    hold(3, 1'b1, 1'b1);
    chk("s037_clear_wins", 32'(state), 32'd0);
    chk("s037_running", 32'(running), 32'd0);

    // Reset mid-RUN, then a long start hold
    load_val = 32'h00F10F00;
    hold(3, 1'b1, 1'b0);
    repeat (7) step();
    rst = 1'b1;
    step();
    chk("s038_rst_state", 32'(state), 32'd0);
    chk("s038_rst_running", 32'(running), 32'd0);
    chk("s038_rst_disp", display, 32'h00F10F00);
    rst = 1'b0;
    trans = 0;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      prev = state;
      step();
      if (state !== prev) trans++;
    end
    start = 1'b0;
    chk("s038_one_transition", 32'(trans), 32'd1);
    chk("s038_run", 32'(state), 32'd1);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: load_val = $urandom();
        1: load_val = {8'h00, 4'hF, 8'h00, 4'hF, 4'h0, 4'($urandom_range(1, 4))};
        2: load_val = 32'h00F00F00;
        default: load_val = {8'h00, 4'hF, 4'h0, 4'($urandom_range(0, 15)), 4'hF,
                             8'($urandom())};
      endcase
      case ($urandom_range(0, 5))
        0, 1: hold($urandom_range(1, 5), 1'b1, 1'b0);
        2: hold($urandom_range(1, 5), 1'b0, 1'b1);
        3: hold($urandom_range(1, 5), 1'b1, 1'b1);
        4: begin
          rst = 1'b1;
          step();
          rst = 1'b0;
        end
        default: ;
      endcase
      repeat ($urandom_range(1, 30)) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
